// File: rtl/watch_pkg.sv
// Shared types and constants for the HH:MM watch: mode encodings, digit limits,
// the 7-segment code table and small digit-stepping helpers.
package watch_pkg;

  typedef enum logic [2:0] {
    RUN     = 3'd0,
    EDIT_ML = 3'd1,
    EDIT_MH = 3'd2,
    EDIT_HL = 3'd3,
    EDIT_HH = 3'd4
  } mode_e;

  localparam logic [3:0] LIM_9 = 4'd9;
  localparam logic [3:0] LIM_5 = 4'd5;
  localparam logic [3:0] LIM_3 = 4'd3;
  localparam logic [3:0] LIM_2 = 4'd2;

  localparam logic [7:0] BLANK = 8'hFF;
  // NOTE: a constant table synthesises to ROM/logic, so it has no reset and needs none.
  localparam logic [7:0] SEG_TBL [10] = '{8'hC0, 8'hF9, 8'hA4, 8'hB0, 8'h99,
                                          8'h92, 8'h82, 8'hF8, 8'h80, 8'h90};

  function automatic logic [7:0] seg_code(input logic [3:0] d);
    if (d <= LIM_9) return SEG_TBL[d];
    return BLANK;
  endfunction

  // Wrap-around step of one digit within 0..lim.
  function automatic logic [3:0] step(input logic [3:0] v, input logic [3:0] lim,
                                      input logic up);
    if (up) return (v >= lim) ? 4'd0 : v + 4'd1;
    return (v == 4'd0) ? lim : v - 4'd1;
  endfunction

  function automatic mode_e next_mode(input mode_e m);
    case (m)
      RUN:     return EDIT_ML;
      EDIT_ML: return EDIT_MH;
      EDIT_MH: return EDIT_HL;
      EDIT_HL: return EDIT_HH;
      default: return RUN;
    endcase
  endfunction

  function automatic logic [1:0] mode_digit(input mode_e m);
    case (m)
      EDIT_MH: return 2'd1;
      EDIT_HL: return 2'd2;
      EDIT_HH: return 2'd3;
      default: return 2'd0;
    endcase
  endfunction

endpackage

// File: rtl/key_debounce.sv
// One push-button: 2-flop synchroniser, stable-low counter and a single
// one-cycle press pulse per press (no auto-repeat while held).
module key_debounce #(
  parameter int DB_CYC = 540_000
) (
  input  logic clk,
  input  logic rst,
  input  logic i_key_n,
  output logic o_press
);

  localparam int CW = $clog2(DB_CYC + 1);

  logic [1:0]    r_sync;
  logic [CW-1:0] r_cnt;
  logic          r_press;

  // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_sync  <= 2'b11;
      r_cnt   <= '0;
      r_press <= 1'b0;
    end else begin
      r_sync  <= {r_sync[0], i_key_n};
      r_press <= 1'b0;
      if (r_sync[1]) begin
        r_cnt <= '0;
      end else if (r_cnt != CW'(DB_CYC)) begin
        // Counter saturates at DB_CYC, which is what suppresses repeats.
        r_cnt <= r_cnt + 1'b1;
        if (r_cnt == CW'(DB_CYC - 1)) r_press <= 1'b1;
      end
    end
  end

  assign o_press = r_press;

endmodule

// File: rtl/digital_watch_core.sv
// 24-hour HH:MM watch with three-button digit editing, 1 Hz LED and a
// multiplexed active-low 4-digit 7-segment display driver.
module digital_watch_core #(
  parameter int CLK_FRE  = 27_000_000,
  parameter int SCAN_DIV = 27_000,
  parameter int DB_CYC   = 540_000
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [2:0] key,
  output logic       led,
  output logic [3:0] dig,
  output logic [7:0] smg
);

  import watch_pkg::*;

  localparam int PW = $clog2(CLK_FRE);
  localparam int SW = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;

  logic          w_p_mode, w_p_inc, w_p_dec;
  logic          w_act_mode, w_act_inc, w_act_dec;
  logic [PW-1:0] r_pre, w_pre_nxt;
  logic          w_sec_tick, r_led;
  logic [5:0]    r_sec;
  logic [3:0]    r_ml, r_mh, r_hl, r_hh;
  logic [3:0]    w_hl_lim, w_hh_step, w_digit;
  mode_e         r_state;
  logic [SW-1:0] r_sdiv;
  logic [1:0]    r_sidx;
  logic [3:0]    r_dig;
  logic [7:0]    r_smg, w_seg;

  key_debounce #(.DB_CYC(DB_CYC)) u_db_mode (.clk(clk), .rst(rst), .i_key_n(key[0]), .o_press(w_p_mode));
  key_debounce #(.DB_CYC(DB_CYC)) u_db_inc  (.clk(clk), .rst(rst), .i_key_n(key[1]), .o_press(w_p_inc));
  key_debounce #(.DB_CYC(DB_CYC)) u_db_dec  (.clk(clk), .rst(rst), .i_key_n(key[2]), .o_press(w_p_dec));

  assign w_act_mode = w_p_mode;
  assign w_act_inc  = w_p_inc & ~w_p_mode;
  assign w_act_dec  = w_p_dec & ~w_p_mode & ~w_p_inc;

  assign w_sec_tick = (r_pre == PW'(CLK_FRE - 1));
  assign w_pre_nxt  = w_sec_tick ? '0 : r_pre + 1'b1;

  // led is registered from the next count, so it equals (count < CLK_FRE/2).
  always_ff @(posedge clk) begin
    if (rst) begin
      r_pre <= '0;
      r_led <= 1'b0;
    end else begin
      r_pre <= w_pre_nxt;
      r_led <= (w_pre_nxt < PW'(CLK_FRE / 2));
    end
  end

  assign w_hl_lim  = (r_hh == LIM_2) ? LIM_3 : LIM_9;
  assign w_hh_step = step(r_hh, LIM_2, w_act_inc);

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= RUN;
      r_sec   <= '0;
      r_ml    <= '0;
      r_mh    <= '0;
      r_hl    <= '0;
      r_hh    <= '0;
    end else begin
      if (w_act_mode) r_state <= next_mode(r_state);
      if (r_state == RUN) begin
        if (w_sec_tick) begin
          if (r_sec == 6'd59) begin
            r_sec <= '0;
            if (r_ml == LIM_9) begin
              r_ml <= '0;
              if (r_mh == LIM_5) begin
                r_mh <= '0;
                if (r_hh == LIM_2 && r_hl == LIM_3) begin
                  r_hl <= '0;
                  r_hh <= '0;
                end else if (r_hl == LIM_9) begin
                  r_hl <= '0;
                  r_hh <= r_hh + 4'd1;
                end else begin
                  r_hl <= r_hl + 4'd1;
                end
              end else begin
                r_mh <= r_mh + 4'd1;
              end
            end else begin
              r_ml <= r_ml + 4'd1;
            end
          end else begin
            r_sec <= r_sec + 6'd1;
          end
        end
      end else begin
        r_sec <= '0;
        if (w_act_inc || w_act_dec) begin
          case (r_state)
            EDIT_ML: r_ml <= step(r_ml, LIM_9, w_act_inc);
            EDIT_MH: r_mh <= step(r_mh, LIM_5, w_act_inc);
            EDIT_HL: r_hl <= step(r_hl, w_hl_lim, w_act_inc);
            EDIT_HH: begin
              r_hh <= w_hh_step;
              if (w_hh_step == LIM_2 && r_hl > LIM_3) r_hl <= LIM_3;
            end
            default: ;
          endcase
        end
      end
    end
  end

  always_comb begin
    // NOTE: every always_comb output gets a default first, so no path can infer a latch.
    w_digit = r_ml;
    case (r_sidx)
      2'd1:    w_digit = r_mh;
      2'd2:    w_digit = r_hl;
      2'd3:    w_digit = r_hh;
      default: w_digit = r_ml;
    endcase
    w_seg = seg_code(w_digit);
    if (r_sidx == 2'd2 && r_led) w_seg[7] = 1'b0;
    if (r_state != RUN && mode_digit(r_state) == r_sidx && !r_led) w_seg = BLANK;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_sdiv <= '0;
      r_sidx <= '0;
      r_dig  <= 4'hF;
      r_smg  <= BLANK;
    end else begin
      r_dig <= ~(4'b0001 << r_sidx);
      r_smg <= w_seg;
      if (r_sdiv == SW'(SCAN_DIV - 1)) begin
        r_sdiv <= '0;
        r_sidx <= r_sidx + 2'd1;
      end else begin
        r_sdiv <= r_sdiv + 1'b1;
      end
    end
  end

  assign led = r_led;
  assign dig = r_dig;
  assign smg = r_smg;

endmodule

// File: tb/tb_digital_watch_core.sv
// Scoreboard bench for digital_watch_core: stimulus queues expected values,
// a monitor decodes the scanned display and compares each queued entry.
module tb_digital_watch_core;

  localparam int CLK_FRE  = 100;
  localparam int SCAN_DIV = 4;
  localparam int DB_CYC   = 5;

  typedef enum {K_DIG, K_SMG, K_LED, K_STATE, K_SEC, K_DISP} kind_e;
  typedef struct {
    string       name;
    kind_e       kind;
    logic [15:0] exp;
  } chk_t;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic [2:0] key = 3'b111;
  logic       led;
  logic [3:0] dig;
  logic [7:0] smg;

  int   n_vec = 0;
  int   n_miss = 0;
  int   cyc = 0;
  chk_t q[$];
  logic [3:0] disp [4];

  digital_watch_core #(.CLK_FRE(CLK_FRE), .SCAN_DIV(SCAN_DIV), .DB_CYC(DB_CYC)) dut (
    .clk(clk), .rst(rst), .key(key), .led(led), .dig(dig), .smg(smg)
  );

  always #5 clk = ~clk;

  // Edges since reset release; equals the prescaler count modulo CLK_FRE.
  always @(posedge clk) cyc <= rst ? 0 : cyc + 1;

  function automatic logic [3:0] decode(input logic [7:0] s);
    case (s | 8'h80)
      8'hC0: return 4'd0;  8'hF9: return 4'd1;  8'hA4: return 4'd2;
      8'hB0: return 4'd3;  8'h99: return 4'd4;  8'h92: return 4'd5;
      8'h82: return 4'd6;  8'hF8: return 4'd7;  8'h80: return 4'd8;
      8'h90: return 4'd9;
      default: return 4'hE;
    endcase
  endfunction

  task automatic check(input string name, input kind_e kind, input logic [15:0] exp);
    chk_t c;
    c.name = name;
    c.kind = kind;
    c.exp  = exp;
    q.push_back(c);
  endtask

  task automatic fail_now(input string name);
    n_vec++;
    n_miss++;
    $display("FAIL %s: bound expired, required event not seen", name);
  endtask

  // Monitor: refresh the decoded display, then drain the scoreboard.
  initial begin
    forever begin
      @(negedge clk);
      #1;
      for (int i = 0; i < 4; i++) begin
        logic [3:0] sel;
        sel = 4'b0001 << i;
        if (dig == ~sel && smg != 8'hFF) disp[i] = decode(smg);
      end
      while (q.size() > 0) begin
        chk_t        c;
        logic [15:0] act;
        c = q.pop_front();
        case (c.kind)
          K_DIG:   act = {12'd0, dig};
          K_SMG:   act = {8'd0, smg};
          K_LED:   act = {15'd0, led};
          K_STATE: act = 16'(dut.r_state);
          K_SEC:   act = 16'(dut.r_sec);
          default: act = {disp[3], disp[2], disp[1], disp[0]};
        endcase
        n_vec++;
        if (act !== c.exp) begin
          n_miss++;
          $display("FAIL %s: got %h, required %h", c.name, act, c.exp);
        end
      end
    end
  end

  task automatic tick(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic press(input logic [2:0] mask);
    key = ~mask;
    tick(DB_CYC + 6);
    key = 3'b111;
    tick(6);
  endtask

  task automatic wait_phase(input int ph);
    int k = 0;
    while ((cyc % CLK_FRE) != ph && k < 2 * CLK_FRE) begin
      tick(1);
      k++;
    end
    if ((cyc % CLK_FRE) != ph) fail_now("wait_phase");
  endtask

  // Waits for a cycle where the minutes_h digit is on display with the given led phase.
  task automatic wait_mh_slot(input logic led_hi);
    int k = 0;
    while (!(((cyc - 1) % 16) inside {[4:7]} && ((((cyc - 1) % CLK_FRE) < 50) == led_hi))
           && k < 3 * CLK_FRE) begin
      tick(1);
      k++;
    end
    if (!(((cyc - 1) % 16) inside {[4:7]})) fail_now("wait_mh_slot");
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    tick(3);
    check("rst_dig", K_DIG, 16'hF);
    check("rst_smg", K_SMG, 16'hFF);
    check("rst_led", K_LED, 16'h0);
    check("rst_state", K_STATE, 16'h0);
    rst = 1'b0;
    tick(1);
    check("scan0_dig", K_DIG, 16'hE);
    check("scan0_smg", K_SMG, 16'hC0);
    check("led_first", K_LED, 16'h1);
    tick(4);
    check("scan1_dig", K_DIG, 16'hD);
    check("scan1_smg", K_SMG, 16'hC0);
    tick(4);
    check("scan2_dig", K_DIG, 16'hB);
    check("scan2_dp", K_SMG, 16'h40);
    tick(4);
    check("scan3_dig", K_DIG, 16'h7);
    check("scan3_smg", K_SMG, 16'hC0);
    tick(36);
    check("led_49", K_LED, 16'h1);
    tick(1);
    check("led_fall_50", K_LED, 16'h0);
    tick(49);
    check("led_99", K_LED, 16'h0);
    tick(1);
    check("led_rise_100", K_LED, 16'h1);
    tick(5899);
    check("sec_59", K_SEC, 16'd59);
    tick(1);
    check("sec_wrap", K_SEC, 16'd0);
    tick(100);
    check("sec_after", K_SEC, 16'd1);
    check("disp_0001", K_DISP, 16'h0001);

    press(3'b001);
    check("state_ml", K_STATE, 16'd1);
    check("sec_held", K_SEC, 16'd0);
    press(3'b100);
    repeat (11) press(3'b010);
    tick(120);
    check("ml_inc11", K_DISP, 16'h0001);
    press(3'b100);
    press(3'b100);
    tick(120);
    check("ml_dec_wrap", K_DISP, 16'h0009);
    key = 3'b101;
    tick(3);
    key = 3'b111;
    tick(120);
    check("glitch", K_DISP, 16'h0009);

    repeat (3) press(3'b001);
    check("state_hh", K_STATE, 16'd4);
    press(3'b010);
    repeat (4) press(3'b001);
    check("state_hl", K_STATE, 16'd3);
    repeat (9) press(3'b010);
    tick(120);
    check("hl_to_9", K_DISP, 16'h1909);
    press(3'b010);
    tick(120);
    check("hl_wrap", K_DISP, 16'h1009);
    repeat (3) press(3'b100);
    tick(120);
    check("hl_dec", K_DISP, 16'h1709);
    press(3'b001);
    press(3'b010);
    tick(120);
    check("hh_clamp", K_DISP, 16'h2309);
    check("state_hh2", K_STATE, 16'd4);
    press(3'b011);
    check("prio_state", K_STATE, 16'd0);
    tick(120);
    check("prio_time", K_DISP, 16'h2309);

    press(3'b001);
    press(3'b001);
    press(3'b100);
    press(3'b001);
    press(3'b001);
    wait_phase(0);
    press(3'b001);
    wait_phase(50);
    check("run_again", K_STATE, 16'd0);
    check("sec_restart", K_SEC, 16'd0);
    tick(1);
    wait_phase(50);
    check("sec_count", K_SEC, 16'd1);
    check("disp_2359", K_DISP, 16'h2359);
    tick(5800);
    check("sec_59b", K_SEC, 16'd59);
    check("disp_2359b", K_DISP, 16'h2359);
    tick(50);
    check("day_wrap_sec", K_SEC, 16'd0);
    tick(120);
    check("day_wrap", K_DISP, 16'h0000);

    press(3'b001);
    press(3'b001);
    check("state_mh", K_STATE, 16'd2);
    wait_mh_slot(1'b0);
    check("blank_dig", K_DIG, 16'hD);
    check("blank_smg", K_SMG, 16'hFF);
    wait_mh_slot(1'b1);
    check("unblank_dig", K_DIG, 16'hD);
    check("unblank_smg", K_SMG, 16'hC0);

    rst = 1'b1;
    tick(1);
    check("mrst_state", K_STATE, 16'd0);
    check("mrst_dig", K_DIG, 16'hF);
    check("mrst_smg", K_SMG, 16'hFF);
    check("mrst_led", K_LED, 16'h0);
    tick(2);
    rst = 1'b0;
    tick(120);
    check("mrst_time", K_DISP, 16'h0000);
    tick(2);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
    $finish;
  end

endmodule

// File: doc/digital_watch_core.md
# digital_watch_core

HH:MM digital clock for the 4-digit 7-segment board display. It keeps 24-hour time from a single clock and lets the user edit each digit with three push-buttons. It drives a multiplexed, active-low common-anode display and a 1 Hz seconds LED. It sits directly under the board top and combines time generation with display scanning.

## Interface
- `CLK_FRE`, 27_000_000: clock frequency in Hz; one second = `CLK_FRE` cycles.
- `SCAN_DIV`, 27_000: cycles per digit in the display scan (1 ms).
- `DB_CYC`, 540_000: debounce stable-time in cycles (20 ms).
- `clk` input 1: single clock, all logic on rising edge.
- `rst` input 1: reset; synchronous, active-high.
- `key` input 3: raw push-buttons, active-low; [0] mode, [1] increment, [2] decrement.
- `led` output 1: seconds indicator.
- `dig` output 4: digit select, active-low one-hot; [0] minutes_l, [1] minutes_h, [2] hour_l, [3] hour_h.
- `smg` output 8: segments, active-low; bit7 dp, bits6..0 = g..a.

## Operation
- **Key conditioning:**
  - Each key is synchronised through 2 flops.
  - A key is accepted once it has been stable low for `DB_CYC` cycles.
  - This yields a one-cycle press pulse; holding the key gives no repeat.
  - Pulse priority when coincident: key[0] > key[1] > key[2]. Only one action is taken per cycle.
- **Modes (3-bit `state`):**
  - 0 RUN, 1 EDIT_ML, 2 EDIT_MH, 3 EDIT_HL, 4 EDIT_HH.
  - The mode pulse advances 0→1→2→3→4→0.
  - Inc/dec pulses are ignored in RUN.
- **Prescaler:**
  - Free-running 0..`CLK_FRE`-1, running in all modes.
  - `led` = 1 while count < `CLK_FRE`/2, else 0.
  - At the wrap (count = `CLK_FRE`-1), a one-cycle `sec_tick` is generated.
- **Time keeping in RUN:**
  - `sec_tick` advances seconds 0..59.
  - Carry chain: seconds → minutes_l (0..9) → minutes_h (0..5) → hour_l → hour_h.
  - hour_l wraps at 9, or at 3 when hour_h = 2. hour_h runs 0..2.
  - 23:59:59 → 00:00:00.
- **Time keeping in EDIT modes:**
  - The seconds counter is held at 0; the prescaler keeps running.
- **Edit rules:** the selected digit changes alone, with no carry into neighbours.
  - minutes_l: 0..9 wrap both ways.
  - minutes_h: 0..5 wrap both ways.
  - hour_l: upper limit is 9, or 3 if hour_h = 2; wraps both ways.
  - hour_h: 0..2 wrap both ways. Entering 2 clamps hour_l to 3 if it is > 3.
- **Display:**
  - The scan index 0..3 advances every `SCAN_DIV` cycles; the matching `dig` bit is driven low.
  - Segment codes 0..9: C0, F9, A4, B0, 99, 92, 82, F8, 80, 90 (hex, dp off).
  - The dp of the hour_l digit is lit (bit7 = 0) while `led` = 1 (colon blink).
  - In EDIT modes the selected digit is blanked (`smg` = FF) while `led` = 0.

## Timing
- **Reset values:**
  - time 00:00; seconds, prescaler and scan counters 0; `state` = RUN.
  - `led` = 0; `dig` = 1111; `smg` = FF.
  - Reset mid-edit returns to RUN at 00:00.
- **Display output timing:**
  - `dig`/`smg` are registered.
  - In the first cycle after `rst` deasserts, `dig` = 1110 with the minutes_l code.
  - A digit change appears on `smg` within 1 cycle of its register update.
- **Key latency:** a press is accepted `DB_CYC` + 3 cycles after `key` goes low, and the digit updates on the next cycle.
- **Minute rollover:** `sec_tick` with seconds = 59 updates minutes in the same cycle the seconds wrap.
- **First `led` falling edge:** `CLK_FRE`/2 cycles after reset.

## Structure
- Shared package `watch_pkg`: mode encodings (RUN, EDIT_*), digit limit constants (9, 5, 3, 2), and the 10-entry segment table plus BLANK = FF.
- One sub-module, `key_debounce` (sync + stable counter + press pulse), instantiated three times.
- Time counters, edit logic, prescaler and scan mux live in the top.

## Test plan
All scenarios use `CLK_FRE` = 100, `SCAN_DIV` = 4, `DB_CYC` = 5.
- Reset, run 60×100 cycles → time 00:01. `led` toggles every 50 cycles. `dig` cycles 1110, 1101, 1011, 0111 every 4 cycles, with `smg` = C0, C0, C0/40 (dp), C0.
- Force time 23:59 and seconds 59, then one `sec_tick` → 00:00, seconds 0.
- Mode press → `state` 1. Inc ×11 → minutes_l 1. Dec from 0 → 9. A 3-cycle glitch on the key causes no action.
- In EDIT_HL with hour_h = 1: inc to 9, inc → 0. Then set hour_h 1→2 with hour_l = 7 → hour_l clamps to 3. Display reads 23.
- Keys [0] and [1] low simultaneously → only the mode advances. Five mode presses → RUN. Seconds restart from 0.
- In EDIT_MH with `led` = 0 → `smg` = FF while `dig` = 1101. Assert `rst` mid-edit → RUN, 00:00, `dig` = 1111, `smg` = FF.
